// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake and IF/ID register.
// A 4-state FSM reconciles redirects, decode stalls and slow memory without losing or duplicating instructions.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] Gap      = 32'd4,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] newAddress_branch,
    input  logic        jump,
    input  logic [31:0] jumpAddress,
    output logic        imemReq,
    output logic [31:0] imemAddress,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_newAddress_next,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_next_q, ifid_next_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect = branchTaken | jump;
    assign target   = branchTaken ? newAddress_branch : jumpAddress;
    assign pc_inc   = pc_q + Gap;

    // Request and address are Moore outputs: they depend only on state and pc.
    assign imemReq              = (state_q == FETCH) || (state_q == DRAIN);
    assign imemAddress          = pc_q;
    assign pc                   = pc_q;
    assign ifid_instruction     = ifid_instr_q;
    assign ifid_newAddress_next = ifid_next_q;
    assign ifid_valid           = ifid_valid_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        pending_d    = pending_q;
        ifid_instr_d = ifid_instr_q;
        ifid_next_d  = ifid_next_q;
        ifid_valid_d = ifid_valid_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) pc_d = target;
            end
            FETCH: begin
                if (imemReady) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (stall) begin
                        hold_buf_d = imemData;
                        state_d    = HOLD;
                    end else begin
                        ifid_instr_d = imemData;
                        ifid_next_d  = pc_inc;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_inc;
                    end
                end else if (redirect) begin
                    pending_d = target;
                    state_d   = DRAIN;
                end else if (!stall) begin
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    ifid_instr_d = hold_buf_q;
                    ifid_next_d  = pc_inc;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_inc;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                // The stale access must complete before the redirect target can be requested.
                if (redirect) pending_d = target;
                if (imemReady) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = FETCH;
                end
                if (!redirect && !stall) begin
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            hold_buf_q   <= 32'h0;
            pending_q    <= 32'h0;
            ifid_instr_q <= NOP;
            ifid_next_q  <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            pending_q    <= pending_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_next_q  <= ifid_next_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
